// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the data-RAM access controller: instruction types,
// funct3 width codes and FSM states.
package mem_access_ctrl_pkg;

    localparam logic [4:0] LTYPE = 5'b00000;
    localparam logic [4:0] STYPE = 5'b01000;

    localparam logic [2:0] LB3  = 3'd0;
    localparam logic [2:0] LH3  = 3'd1;
    localparam logic [2:0] LW3  = 3'd2;
    localparam logic [2:0] LBU3 = 3'd4;
    localparam logic [2:0] LHU3 = 3'd5;

    localparam logic [2:0] SB3 = 3'd0;
    localparam logic [2:0] SH3 = 3'd1;
    localparam logic [2:0] SW3 = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RDATA = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Load lane select and sign/zero extension; shared with the writeback path.
module mem_access_ctrl_load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfwords look only at addr[1], so a misaligned addr[0] is ignored here.
    always_comb begin
        byte_sel = 8'(word_i >> {addr_lo_i, 3'b000});
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            LB3:     data_o = {{24{byte_sel[7]}}, byte_sel};
            LBU3:    data_o = {24'd0, byte_sel};
            LH3:     data_o = {{16{half_sel[15]}}, half_sel};
            LHU3:    data_o = {16'd0, half_sel};
            LW3:     data_o = word_i;
            default: data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Shares the single-port data RAM between the fetch and load/store requesters.
// Define MEM_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses instead of aligning them.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic [4:0]        d_itype,
    input  logic [2:0]        d_funct3,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_be,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [31:0]       ram_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                fetch_q, fetch_d;
    logic [2:0]          f3_q, f3_d;
    logic [1:0]          alo_q, alo_d;
    logic                if_ack_q, if_ack_d, d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic [31:0]         if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [31:0]         ram_wdata_q, ram_wdata_d;
    logic [3:0]          ram_be_q, ram_be_d;
    logic                ram_we_q, ram_we_d, ram_re_q, ram_re_d;

    logic                grant_if_c, d_ok_c, d_misal_c;
    logic [3:0]          d_be_c;
    logic [31:0]         d_wdata_c, load_data_c;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[1:0], if_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2]};

    // Data wins unless fetch has waited through STARVE_LIMIT data grants.
    assign grant_if_c = if_req && (!d_req || (cnt_q == CNT_W'(STARVE_LIMIT)));

    always_comb begin
        d_ok_c    = 1'b0;
        d_misal_c = 1'b0;
        if (d_itype == LTYPE) begin
            d_ok_c = d_funct3 inside {LB3, LH3, LW3, LBU3, LHU3};
        end else if (d_itype == STYPE) begin
            d_ok_c = d_funct3 inside {SB3, SH3, SW3};
        end
`ifdef MEM_MISALIGN_TRAP_EN
        case (d_funct3[1:0])
            2'd1:    d_misal_c = d_addr[0];
            2'd2:    d_misal_c = |d_addr[1:0];
            default: d_misal_c = 1'b0;
        endcase
`endif
        case (d_funct3[1:0])
            2'd0: begin
                d_be_c    = 4'b0001 << d_addr[1:0];
                d_wdata_c = {4{d_wdata[7:0]}};
            end
            2'd1: begin
                d_be_c    = d_addr[1] ? 4'b1100 : 4'b0011;
                d_wdata_c = {2{d_wdata[15:0]}};
            end
            default: begin
                d_be_c    = 4'b1111;
                d_wdata_c = d_wdata;
            end
        endcase
    end

    mem_access_ctrl_load_align u_load_align (
        .word_i    (ram_rdata),
        .addr_lo_i (alo_q),
        .funct3_i  (f3_q),
        .data_o    (load_data_c)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fetch_d     = fetch_q;
        f3_d        = f3_q;
        alo_d       = alo_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        d_err_d     = d_err_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_be_d    = ram_be_q;
        ram_we_d    = 1'b0;
        ram_re_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_if_c) begin
                    cnt_d      = '0;
                    fetch_d    = 1'b1;
                    ram_addr_d = if_addr[ADDR_W+1:2];
                    ram_be_d   = 4'b1111;
                    ram_re_d   = 1'b1;
                    state_d    = ST_ISSUE;
                end else if (d_req) begin
                    if (if_req) cnt_d = cnt_q + CNT_W'(1);
                    fetch_d = 1'b0;
                    f3_d    = d_funct3;
                    alo_d   = d_addr[1:0];
                    if (!d_ok_c || d_misal_c) begin
                        d_ack_d   = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = 32'd0;
                        state_d   = ST_DONE;
                    end else begin
                        ram_addr_d = d_addr[ADDR_W+1:2];
                        ram_be_d   = d_be_c;
                        if (d_itype == STYPE) begin
                            ram_wdata_d = d_wdata_c;
                            ram_we_d    = 1'b1;
                        end else begin
                            ram_re_d = 1'b1;
                        end
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (ram_we_q) begin
                    d_ack_d   = 1'b1;
                    d_err_d   = 1'b0;
                    d_rdata_d = 32'd0;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (fetch_q) begin
                    if_ack_d   = 1'b1;
                    if_rdata_d = ram_rdata;
                end else begin
                    d_ack_d   = 1'b1;
                    d_err_d   = 1'b0;
                    d_rdata_d = load_data_c;
                end
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            fetch_q     <= 1'b0;
            f3_q        <= 3'd0;
            alo_q       <= 2'd0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 32'd0;
            ram_be_q    <= 4'd0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fetch_q     <= fetch_d;
            f3_q        <= f3_d;
            alo_q       <= alo_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_be_q    <= ram_be_d;
            ram_we_q    <= ram_we_d;
            ram_re_q    <= ram_re_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_be    = ram_be_q;
    assign ram_we    = ram_we_q;
    assign ram_re    = ram_re_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed steps plus random loads/stores/fetches checked
// against a byte-addressed reference memory. Honours MEM_MISALIGN_TRAP_EN.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0;
    logic [31:0] if_addr = 32'd0, d_addr = 32'd0, d_wdata = 32'd0;
    logic [4:0]  d_itype = 5'd0;
    logic [2:0]  d_funct3 = 3'd0;
    logic        if_ack, d_ack, d_err, ram_we, ram_re;
    logic [31:0] if_rdata, d_rdata, ram_wdata, ram_rdata;
    logic [15:0] ram_addr;
    logic [3:0]  ram_be;

    mem_access_ctrl dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_itype(d_itype), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be),
        .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM attached to the DUT
    logic [31:0] ram [0:63];
    logic        ram_clr = 1'b1;
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int w = 0; w < 64; w++) ram[w] <= 32'd0;
        end else begin
            if (ram_re) ram_rdata <= ram[ram_addr[5:0]];
            if (ram_we)
                for (int k = 0; k < 4; k++)
                    if (ram_be[k]) ram[ram_addr[5:0]][8*k +: 8] <= ram_wdata[8*k +: 8];
        end
    end

    int          strobes = 0;
    logic        both_hi = 1'b0;
    logic [3:0]  last_be = 4'd0;
    logic [15:0] last_addr = 16'd0;
    logic        ack_log[$];   // 0 = data grant completed, 1 = fetch
    always @(posedge clk) begin
        if (ram_re || ram_we) begin
            strobes   <= strobes + 1;
            last_be   <= ram_be;
            last_addr <= ram_addr;
        end
        if (ram_re && ram_we) both_hi <= 1'b1;
        if (d_ack)  ack_log.push_back(1'b0);
        if (if_ack) ack_log.push_back(1'b1);
    end

    logic [7:0] ref_mem [0:255];
    int n_checks = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic access_ok(input logic [4:0] it, input logic [2:0] f3, input logic [31:0] a);
        logic ok, mis;
        if (it == LTYPE)      ok = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        else if (it == STYPE) ok = (f3 <= 3'd2);
        else                  ok = 1'b0;
        mis = (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
        return ok && !(TRAP_EN && mis);
    endfunction

    task automatic run_data(input string tag, input logic [4:0] it, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        logic ok;
        int lat, s0, nb, base;
        logic [31:0] exp_rd;
        ok   = access_ok(it, f3, a);
        nb   = 1 << f3[1:0];
        base = int'(a[7:0]) & ~(nb - 1);
        s0   = strobes;
        d_itype = it; d_funct3 = f3; d_addr = a; d_wdata = wd; d_req = 1'b1;
        lat = 0;
        do begin @(posedge clk); lat++; @(negedge clk); end while (!d_ack && lat < 20);
        rd = d_rdata;
        check({tag, " err"}, 32'(d_err), 32'(!ok));
        if (!ok) begin
            check({tag, " rej latency"}, 32'(lat), 32'd1);
            check({tag, " rej rdata"}, rd, 32'd0);
            check({tag, " rej strobes"}, 32'(strobes - s0), 32'd0);
        end else if (it == STYPE) begin
            check({tag, " st latency"}, 32'(lat), 32'd2);
            check({tag, " st be"}, 32'(last_be), 32'(((1 << nb) - 1) << (base % 4)));
            check({tag, " st addr"}, 32'(last_addr), 32'(base / 4));
            check({tag, " st strobes"}, 32'(strobes - s0), 32'd1);
            for (int k = 0; k < nb; k++) ref_mem[base + k] = wd[8*k +: 8];
        end else begin
            exp_rd = 32'd0;
            for (int k = 0; k < nb; k++) exp_rd = exp_rd | (32'(ref_mem[base + k]) << (8 * k));
            if (!f3[2] && nb < 4 && exp_rd[8*nb-1]) exp_rd = exp_rd | ~((32'd1 << (8 * nb)) - 32'd1);
            check({tag, " ld latency"}, 32'(lat), 32'd3);
            check({tag, " ld rdata"}, rd, exp_rd);
            check({tag, " ld addr"}, 32'(last_addr), 32'(base / 4));
        end
        d_req = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic fetch_op(input string tag, input logic [31:0] a);
        int lat, base;
        logic [31:0] exp_w;
        base  = int'(a[7:0]) & ~3;
        exp_w = {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
        if_addr = a; if_req = 1'b1;
        lat = 0;
        do begin @(posedge clk); lat++; @(negedge clk); end while (!if_ack && lat < 20);
        check({tag, " if latency"}, 32'(lat), 32'd3);
        check({tag, " if rdata"}, if_rdata, exp_w);
        check({tag, " if be"}, 32'(last_be), 32'hF);
        if_req = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " strobes/acks"}, 32'({if_ack, d_ack, d_err, ram_we, ram_re}), 32'd0);
        check({tag, " if_rdata"}, if_rdata, 32'd0);
        check({tag, " d_rdata"}, d_rdata, 32'd0);
        check({tag, " ram be/addr"}, 32'({ram_be, ram_addr}), 32'd0);
        check({tag, " ram_wdata"}, ram_wdata, 32'd0);
    endtask

    initial begin
        logic [31:0] rd, a;
        logic [4:0]  it;
        logic [2:0]  f3;
        int n0, r;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        ram_clr = 1'b0;
        reset   = 1'b1;
        @(negedge clk);

        run_data("sw10", STYPE, SW3, 32'h10, 32'hDEADBEEF, rd);
        run_data("lw10", LTYPE, LW3, 32'h10, 32'h0, rd);
        check("lw10 value", rd, 32'hDEADBEEF);

        run_data("sw20", STYPE, SW3, 32'h20, 32'h80FF7F01, rd);
        run_data("lb23", LTYPE, LB3, 32'h23, 32'h0, rd);
        check("lb23 value", rd, 32'hFFFFFF80);
        run_data("lbu23", LTYPE, LBU3, 32'h23, 32'h0, rd);
        check("lbu23 value", rd, 32'h00000080);
        run_data("lh22", LTYPE, LH3, 32'h22, 32'h0, rd);
        check("lh22 value", rd, 32'hFFFF80FF);
        run_data("lhu22", LTYPE, LHU3, 32'h22, 32'h0, rd);
        check("lhu22 value", rd, 32'h000080FF);

        run_data("sb31", STYPE, SB3, 32'h31, 32'h000000AB, rd);
        check("sb31 be", 32'(last_be), 32'b0010);
        run_data("lw30", LTYPE, LW3, 32'h30, 32'h0, rd);
        check("lw30 value", rd, 32'h0000AB00);

        run_data("sw40", STYPE, SW3, 32'h40, 32'h12345678, rd);
        run_data("lw42", LTYPE, LW3, 32'h42, 32'h0, rd);
        check("lw42 value", rd, TRAP_EN ? 32'h0 : 32'h12345678);
        run_data("sh45", STYPE, SH3, 32'h45, 32'h0000CAFE, rd);
        run_data("bad f3", LTYPE, 3'd3, 32'h10, 32'h0, rd);
        run_data("bad type", 5'b11000, SW3, 32'h10, 32'h0, rd);

        fetch_op("if13", 32'h13);

        // Both requesters held high: fetch must get every fifth grant
        d_itype = LTYPE; d_funct3 = LW3; d_addr = 32'h10; if_addr = 32'h10;
        n0 = ack_log.size();
        d_req = 1'b1; if_req = 1'b1;
        for (int c = 0; c < 300 && ack_log.size() < n0 + 10; c++) @(negedge clk);
        d_req = 1'b0; if_req = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        check("starve grants", 32'(ack_log.size() - n0), 32'd10);
        for (int g = 0; g < 10; g++)
            if (n0 + g < ack_log.size())
                check($sformatf("grant%0d", g), 32'(ack_log[n0 + g]), (g % 5 == 4) ? 32'd1 : 32'd0);

        // Reset while a load is waiting for RAM data
        d_itype = LTYPE; d_funct3 = LW3; d_addr = 32'h20; d_req = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        check_outputs_zero("mid reset");
        d_req = 1'b0;
        n0 = ack_log.size();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("no ack after reset", 32'(ack_log.size() - n0), 32'd0);
        fetch_op("if20 after reset", 32'h20);

        for (int i = 0; i < 48; i++) begin
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 255));
            if (r < 4) begin
                f3 = 3'($urandom_range(0, 3));
                run_data($sformatf("rnd%0d st", i), STYPE, f3, a, $urandom, rd);
            end else if (r < 8) begin
                f3 = 3'($urandom_range(0, 7));
                run_data($sformatf("rnd%0d ld", i), LTYPE, f3, a, 32'h0, rd);
            end else if (r == 8) begin
                it = 5'($urandom_range(1, 31));
                if (it == STYPE) it = 5'h1F;
                f3 = 3'($urandom_range(0, 7));
                run_data($sformatf("rnd%0d bad", i), it, f3, a, $urandom, rd);
            end else begin
                fetch_op($sformatf("rnd%0d", i), a);
            end
        end

        check("re/we never both high", 32'(both_hi), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences and shares the single-port data RAM between the instruction-fetch requester and the memory-stage load/store requester.
- Arbitrates between the two requesters.
- Issues word-addressed RAM commands with byte enables.
- Aligns and sign/zero-extends load data, and flags misaligned or unsupported accesses.
- Sits between the fetch/memory pipeline stages and the RAM array.

Parameters:
- ADDR_W, 16: RAM word-address width; byte address bits [ADDR_W+1:2] form the word address.
- STARVE_LIMIT, 4: consecutive data grants allowed while if_req is pending before fetch is forced.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_ack.
- if_addr  in  32  fetch byte address; low two bits ignored.
- if_ack  out  1  one-cycle completion pulse.
- if_rdata  out  32  fetched word; valid with if_ack.
- d_req  in  1  data request; held with its fields until d_ack.
- d_itype  in  5  instruction type (LTYPE or STYPE).
- d_funct3  in  3  ir[14:12] width/sign code.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, right-justified.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  32  extended load data; valid with d_ack.
- d_err  out  1  valid with d_ack: access rejected.
- ram_addr  out  ADDR_W  word address.
- ram_wdata  out  32  lane-positioned write data.
- ram_be  out  4  byte enables.
- ram_we  out  1  write strobe.
- ram_re  out  1  read strobe.
- ram_rdata  in  32  synchronous read data, valid the cycle after ram_re is sampled.

Behaviour:
- Reset (asynchronous, mid-operation included):
  - All outputs go to 0; state goes to IDLE; starve counter clears.
  - An in-flight access is abandoned with no ack.
  - ram_we drops immediately.
- FSM states: IDLE, ISSUE, RDATA, DONE.
  - IDLE→ISSUE on grant, with RAM command registered.
  - ISSUE→RDATA for loads and fetch.
  - ISSUE→DONE for stores.
  - RDATA→DONE; data is captured at the end of RDATA.
  - DONE→IDLE; the ack is high only during DONE.
- Latency from the req-sampling edge:
  - Store: ack 2 cycles later.
  - Load/fetch: ack 3 cycles later.
  - Rejected access: ack 1 cycle later (IDLE→DONE directly, no RAM strobe).
- Requests are sampled only in IDLE, so a req still high during DONE is not re-sampled until IDLE.
- ram_re and ram_we are high only in ISSUE and are never both high.
- Arbitration in IDLE:
  - d_req wins over if_req.
  - The starve counter increments on each data grant while if_req is high, saturating at STARVE_LIMIT.
  - At STARVE_LIMIT, fetch wins; any fetch grant clears the counter.
- Stores (STYPE):
  - funct3 0 (SB): ram_be = 1<<addr[1:0], byte replicated on all lanes.
  - funct3 1 (SH): ram_be = addr[1] ? 1100 : 0011, half replicated.
  - funct3 2 (SW): ram_be = 1111.
- Loads (LTYPE), lane chosen by addr[1:0]:
  - LB (0): byte sign-extended.
  - LBU (4): byte zero-extended.
  - LH (1) / LHU (5): half selected by addr[1], sign-/zero-extended.
  - LW (2): full word.
- Rejected accesses, independent of macro: other funct3 values, or d_itype not LTYPE/STYPE.
  - Rejected, no RAM access, d_rdata=0, d_err=1.
- Fetch: always ram_be=1111; if_rdata is the raw word; no error path.
- d_rdata, if_rdata and d_err hold their values until the next ack of the same port.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Halfword access with addr[0]=1 is rejected: no RAM access, d_err=1, d_rdata=0, 1-cycle ack.
  - Word access with addr[1:0]≠0 is rejected the same way.
- Undefined:
  - Misaligned low bits are forced to alignment: halfword uses addr[1] only; word ignores addr[1:0].
  - d_err asserts only for unsupported type/funct3.

Decomposition:
- Shared package/include holds:
  - LTYPE and STYPE codes.
  - LB3/LH3/LW3/LBU3/LHU3 and SB3/SH3/SW3 funct3 constants.
  - FSM state encodings.
- One sub-module, load_align: combinational lane select plus sign/zero-extend from (word, addr[1:0], funct3). It is reused by the writeback path.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → ram_be=1111, ram_addr=4; store ack at +2; LW d_rdata=0xDEADBEEF at +3.
- Word 0x80FF7F01 at 0x20; LB 0x23, LBU 0x23, LH 0x22, LHU 0x22 → 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x000080FF.
- SB 0x31 data 0xAB over word 0 → ram_be=0010; readback 0x0000AB00.
- d_req and if_req held high continuously → grant order D,D,D,D,F,D,D,D,D,F (STARVE_LIMIT=4).
- LW 0x42: with MEM_MISALIGN_TRAP_EN → d_err=1, d_rdata=0, no ram_re, ack at +1; without → reads word 0x40, d_err=0.
- Reset deasserted-low during RDATA of a load → no ack, all outputs 0; next fetch completes normally at +3.
